// File: rtl/bus_server_responder.sv
// Server end of the client/arbiter/server handshake: captures the granted client, serves it
// for a fixed number of cycles, then acks (or flags an abort) and keeps per-client counts.
module bus_server_responder #(
    parameter int SERVICE_CYCLES = 3,
    parameter int GUARD_CYCLES   = 1,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   client_1_rq_i,
    input  logic                   client_2_rq_i,
    input  logic                   client_3_rq_i,
    input  logic                   client_4_rq_i,
    input  logic [1:0]             address_to_be_served_i,
    output logic                   server_ack_o,
    output logic [3:0]             client_done_o,
    output logic                   busy_o,
    output logic [1:0]             served_client_o,
    output logic                   abort_pulse_o,
    output logic [4*CNT_WIDTH-1:0] served_count_o
);

    localparam int SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
    localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [SVC_W-1:0] SVC_INIT = SVC_W'(SERVICE_CYCLES - 1);
    localparam logic [GRD_W-1:0] GRD_INIT = GRD_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        ACK,
        ABORT,
        GUARD
    } state_t;

    state_t               state_q;
    logic [SVC_W-1:0]     svc_cnt_q;
    logic [GRD_W-1:0]     grd_cnt_q;
    logic [1:0]           served_client_q;
    logic                 server_ack_q;
    logic [3:0]           client_done_q;
    logic                 busy_q;
    logic                 abort_pulse_q;
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [3:0]           rq;

    assign rq = {client_4_rq_i, client_3_rq_i, client_2_rq_i, client_1_rq_i};

    // Outputs are set on the edge that enters the state they belong to, so they are
    // aligned with the state rather than trailing it by a cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            svc_cnt_q       <= '0;
            grd_cnt_q       <= '0;
            served_client_q <= '0;
            server_ack_q    <= 1'b0;
            client_done_q   <= '0;
            busy_q          <= 1'b0;
            abort_pulse_q   <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            server_ack_q  <= 1'b0;
            client_done_q <= '0;
            abort_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i && rq[address_to_be_served_i]) begin
                        served_client_q <= address_to_be_served_i;
                        svc_cnt_q       <= SVC_INIT;
                        busy_q          <= 1'b1;
                        state_q         <= SERVE;
                    end
                end
                SERVE: begin
                    // A dropped request wins even on the final service cycle.
                    if (!rq[served_client_q]) begin
                        abort_pulse_q <= 1'b1;
                        state_q       <= ABORT;
                    end else if (svc_cnt_q == '0) begin
                        server_ack_q  <= 1'b1;
                        client_done_q <= 4'b0001 << served_client_q;
                        if (cnt_q[served_client_q] != '1)
                            cnt_q[served_client_q] <= cnt_q[served_client_q] + CNT_WIDTH'(1);
                        state_q       <= ACK;
                    end else begin
                        svc_cnt_q <= svc_cnt_q - SVC_W'(1);
                    end
                end
                ACK, ABORT: begin
                    grd_cnt_q <= GRD_INIT;
                    state_q   <= GUARD;
                end
                GUARD: begin
                    if (grd_cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        grd_cnt_q <= grd_cnt_q - GRD_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign server_ack_o    = server_ack_q;
    assign client_done_o   = client_done_q;
    assign busy_o          = busy_q;
    assign served_client_o = served_client_q;
    assign abort_pulse_o   = abort_pulse_q;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign served_count_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

endmodule
